// File: rtl/ethernet_bus_arbiter.sv
// Round-robin arbiter sequencing two requesters onto a DM9000-style 16-bit chip bus.
// Optional stale-lock timeout is built when ETH_ARB_LOCK_TIMEOUT_EN is defined.
module ethernet_bus_arbiter #(
    parameter int STROBE_CYCLES   = 3,
    parameter int RECOVERY_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [1:0]       cmd,
    input  logic [1:0][15:0] wdata,
    output logic [15:0]      rdata,
    output logic [1:0]       ack,
    output logic             eth_cs_n,
    output logic             eth_ior_n,
    output logic             eth_iow_n,
    output logic             eth_cmd,
    output logic [15:0]      eth_sd_o,
    output logic             eth_sd_oe,
    input  logic [15:0]      eth_sd_i,
    output logic             busy,
    output logic             locked
);
    localparam int MAX_CYCLES = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] STROBE_LOAD  = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVERY_CYCLES);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    if (STROBE_CYCLES < 1 || RECOVERY_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_params
        $error("ethernet_bus_arbiter: phase widths and LOCK_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic            owner_r, we_r, cmd_r, rr_r;
    logic            locked_r, lock_owner_r;
    logic            cs_n_r, ior_n_r, iow_n_r, cmd_pin_r, sd_oe_r, busy_r;
    logic [15:0]     sd_o_r, rdata_r;
    logic [1:0]      ack_r;
    logic            accept_s, grant_s, we_cur_s, active_nxt_s, strobe_done_s, tmo_expire_s;

    assign strobe_done_s = (state_r == STROBE) && (cnt_r == CNT_ONE);

    // Arbitration and phase sequencing.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        grant_s     = rr_r;
        case (state_r)
            IDLE: begin
                if (locked_r) begin
                    accept_s = req[lock_owner_r];
                    grant_s  = lock_owner_r;
                end else if (req[0] && req[1]) begin
                    accept_s = 1'b1;
                    grant_s  = rr_r;
                end else if (req[0]) begin
                    accept_s = 1'b1;
                    grant_s  = 1'b0;
                end else if (req[1]) begin
                    accept_s = 1'b1;
                    grant_s  = 1'b1;
                end else begin
                    accept_s = 1'b0;
                    grant_s  = rr_r;
                end
                if (accept_s) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = STROBE;
                cnt_nxt_s   = STROBE_LOAD;
            end
            STROBE: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                state_nxt_s = RECOVER;
                cnt_nxt_s   = RECOVER_LOAD;
            end
            RECOVER: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
        // Pins for the next cycle follow the accepted request or the latched one.
        we_cur_s     = accept_s ? we[grant_s] : we_r;
        active_nxt_s = (state_nxt_s == SETUP) || (state_nxt_s == STROBE) || (state_nxt_s == HOLD);
    end

    // State, counter, access latch and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            cmd_r   <= 1'b0;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                owner_r <= grant_s;
                we_r    <= we[grant_s];
                cmd_r   <= cmd[grant_s];
            end
            if (state_r == HOLD) begin
                rr_r <= ~owner_r;
            end
        end
    end

`ifdef ETH_ARB_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_r;

    assign tmo_expire_s = locked_r && (state_r == IDLE) && !req[lock_owner_r]
                          && (tmo_cnt_r == TW'(LOCK_TIMEOUT - 1));

    // Counts idle cycles in which the lock owner is not requesting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (!locked_r || req[lock_owner_r] || tmo_expire_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_r == IDLE) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end
`else
    assign tmo_expire_s = 1'b0;
`endif

    // Index-write lock: set by an index write, released by the owner's data access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_r     <= 1'b0;
            lock_owner_r <= 1'b0;
        end else if (strobe_done_s) begin
            if (we_r && !cmd_r) begin
                locked_r     <= 1'b1;
                lock_owner_r <= owner_r;
            end else if (cmd_r && (owner_r == lock_owner_r)) begin
                locked_r <= 1'b0;
            end
        end else if (tmo_expire_s) begin
            locked_r <= 1'b0;
        end
    end

    // Registered pin and handshake outputs, computed from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r    <= 1'b1;
            ior_n_r   <= 1'b1;
            iow_n_r   <= 1'b1;
            sd_oe_r   <= 1'b0;
            sd_o_r    <= 16'h0000;
            cmd_pin_r <= 1'b0;
            rdata_r   <= 16'h0000;
            ack_r     <= 2'b00;
            busy_r    <= 1'b0;
        end else begin
            cs_n_r  <= ~active_nxt_s;
            iow_n_r <= ~((state_nxt_s == STROBE) && we_cur_s);
            ior_n_r <= ~((state_nxt_s == STROBE) && !we_cur_s);
            sd_oe_r <= active_nxt_s && we_cur_s;
            ack_r   <= strobe_done_s ? (owner_r ? 2'b10 : 2'b01) : 2'b00;
            busy_r  <= (state_nxt_s != IDLE);
            if (accept_s) begin
                cmd_pin_r <= cmd[grant_s];
                if (we[grant_s]) begin
                    sd_o_r <= wdata[grant_s];
                end
            end
            if (strobe_done_s && !we_r) begin
                rdata_r <= eth_sd_i;
            end
        end
    end

    assign eth_cs_n  = cs_n_r;
    assign eth_ior_n = ior_n_r;
    assign eth_iow_n = iow_n_r;
    assign eth_cmd   = cmd_pin_r;
    assign eth_sd_o  = sd_o_r;
    assign eth_sd_oe = sd_oe_r;
    assign rdata     = rdata_r;
    assign ack       = ack_r;
    assign busy      = busy_r;
    assign locked    = locked_r;
endmodule

// File: tb/tb_ethernet_bus_arbiter.sv
// Directed bench for ethernet_bus_arbiter (S=3, R=4, LOCK_TIMEOUT=8); covers either build
// of ETH_ARB_LOCK_TIMEOUT_EN.
module tb_ethernet_bus_arbiter;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req, we, cmd, ack;
    logic [1:0][15:0] wdata;
    logic [15:0]      rdata, eth_sd_o, eth_sd_i;
    logic             eth_cs_n, eth_ior_n, eth_iow_n, eth_cmd, eth_sd_oe, busy, locked;

    int n_checks = 0;
    int n_errors = 0;

    ethernet_bus_arbiter #(.STROBE_CYCLES(3), .RECOVERY_CYCLES(4), .LOCK_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .cmd(cmd), .wdata(wdata),
        .rdata(rdata), .ack(ack), .eth_cs_n(eth_cs_n), .eth_ior_n(eth_ior_n),
        .eth_iow_n(eth_iow_n), .eth_cmd(eth_cmd), .eth_sd_o(eth_sd_o),
        .eth_sd_oe(eth_sd_oe), .eth_sd_i(eth_sd_i), .busy(busy), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int cyc, output logic [1:0] a, output logic [15:0] rd);
        cyc = -1;
        a   = 2'b00;
        rd  = 16'h0000;
        for (int k = 1; k <= budget && cyc < 0; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                cyc = k;
                a   = ack;
                rd  = rdata;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_single(input int r, input logic w, input logic c, input logic [15:0] d,
                              output int ack_cyc, output int strobe_lo, output int oe_cyc,
                              output logic [15:0] sd_setup, output logic cmd_setup,
                              output logic [15:0] rd_ack, output logic [1:0] ack_val);
        we[r] = w; cmd[r] = c; wdata[r] = d; req[r] = 1'b1;
        ack_cyc = -1; strobe_lo = 0; oe_cyc = 0;
        sd_setup = 16'h0000; cmd_setup = 1'b0; rd_ack = 16'h0000; ack_val = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (w ? !eth_iow_n : !eth_ior_n) strobe_lo++;
            if (eth_sd_oe) oe_cyc++;
            if (k == 1) begin
                sd_setup  = eth_sd_o;
                cmd_setup = eth_cmd;
            end
            if (ack != 2'b00 && ack_cyc < 0) begin
                ack_cyc = k; ack_val = ack; rd_ack = rdata; req[r] = 1'b0;
            end
        end
        req[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c, sl, oe, seen;
        logic [15:0] sd, rd;
        logic        cm;
        logic [1:0]  a;
        int          ack_cyc[4];
        logic [1:0]  ack_val[4];
        int          n_ack;

        rst_n = 1'b0; req = 2'b00; we = 2'b00; cmd = 2'b00;
        wdata = '0; eth_sd_i = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_pins", 32'({eth_cs_n, eth_ior_n, eth_iow_n, eth_sd_oe, eth_cmd}), 32'b11100);
        check("rst_sd_o", 32'(eth_sd_o), 32'h0);
        check("rst_rdata_ack", 32'({rdata, ack}), 32'h0);
        check("rst_busy_locked", 32'({busy, locked}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single data write from requester 0.
        run_single(0, 1'b1, 1'b1, 16'h1234, c, sl, oe, sd, cm, rd, a);
        check("wr_ack_cycle", 32'(c), 32'd5);
        check("wr_ack_val", 32'(a), 32'b01);
        check("wr_iow_low", 32'(sl), 32'd3);
        check("wr_oe_cycles", 32'(oe), 32'd5);
        check("wr_sd_o", 32'(sd), 32'h1234);
        check("wr_cmd_pin", 32'(cm), 32'd1);
        wait_idle(20);

        // Single data read from requester 1.
        eth_sd_i = 16'hBEEF;
        run_single(1, 1'b0, 1'b1, 16'h0000, c, sl, oe, sd, cm, rd, a);
        check("rd_ack_cycle", 32'(c), 32'd5);
        check("rd_ack_val", 32'(a), 32'b10);
        check("rd_ior_low", 32'(sl), 32'd3);
        check("rd_oe_cycles", 32'(oe), 32'd0);
        check("rd_rdata", 32'(rd), 32'hBEEF);
        wait_idle(20);

        // Both requesting continuously: alternating grants every 10 cycles.
        we = 2'b11; cmd = 2'b11; wdata[0] = 16'h1111; wdata[1] = 16'h2222; req = 2'b11;
        n_ack = 0;
        for (int k = 1; k <= 45 && n_ack < 4; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ack_cyc[n_ack] = k; ack_val[n_ack] = ack; n_ack++;
            end
        end
        req = 2'b00;
        check("rr_count", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_val%0d", i), 32'(ack_val[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
            check($sformatf("rr_cyc%0d", i), 32'(ack_cyc[i]), 32'(5 + 10 * i));
        end
        wait_idle(20);

        // Index write locks out requester 1 until requester 0's data read.
        we = 2'b11; cmd = 2'b10; wdata[0] = 16'h0010; wdata[1] = 16'hCAFE; req = 2'b11;
        wait_ack(20, c, a, rd);
        check("lk_idx_ack", 32'(a), 32'b01);
        check("lk_locked_set", 32'(locked), 32'd1);
        req[0] = 1'b0;
        wait_idle(20);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack != 2'b00 || busy) seen++;
        end
        check("lk_blocked", 32'(seen), 32'd0);
        we[0] = 1'b0; cmd[0] = 1'b1; eth_sd_i = 16'h5A5A; req[0] = 1'b1;
        wait_ack(20, c, a, rd);
        req[0] = 1'b0;
        check("lk_data_ack", 32'(a), 32'b01);
        check("lk_data_rdata", 32'(rd), 32'h5A5A);
        check("lk_released", 32'(locked), 32'd0);
        wait_ack(30, c, a, rd);
        check("lk_next_req1", 32'(a), 32'b10);
        req[1] = 1'b0;
        wait_idle(20);

        // Stale lock: owner goes quiet after the index write.
        we = 2'b11; cmd = 2'b10; req = 2'b11;
        wait_ack(20, c, a, rd);
        check("to_idx_ack", 32'(a), 32'b01);
        req[0] = 1'b0;
        wait_idle(20);
        seen = 0;
`ifdef ETH_ARB_LOCK_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (ack != 2'b00) seen++;
        end
        check("to_no_ack_before", 32'(seen), 32'd0);
        check("to_still_locked", 32'(locked), 32'd1);
        @(negedge clk);
        check("to_dropped", 32'(locked), 32'd0);
        wait_ack(20, c, a, rd);
        check("to_req1_served", 32'(a), 32'b10);
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ack != 2'b00) seen++;
        end
        check("to_no_ack", 32'(seen), 32'd0);
        check("to_still_locked", 32'(locked), 32'd1);
        we[0] = 1'b1; cmd[0] = 1'b1; req[0] = 1'b1;
        wait_ack(20, c, a, rd);
        req[0] = 1'b0;
        check("to_owner_data", 32'(a), 32'b01);
        check("to_released", 32'(locked), 32'd0);
        wait_ack(30, c, a, rd);
        check("to_req1_served", 32'(a), 32'b10);
`endif
        req[1] = 1'b0;
        wait_idle(20);

        // Reset during the strobe of a locked owner's data write.
        we[0] = 1'b1; cmd[0] = 1'b0; req[0] = 1'b1;
        wait_ack(20, c, a, rd);
        req[0] = 1'b0;
        wait_idle(20);
        check("rs_locked_before", 32'(locked), 32'd1);
        cmd[0] = 1'b1; wdata[0] = 16'hA55A; req[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rs_in_strobe", 32'({eth_iow_n, eth_sd_oe}), 32'b01);
        rst_n = 1'b0;
        #1;
        check("rs_strobes", 32'({eth_cs_n, eth_ior_n, eth_iow_n}), 32'b111);
        check("rs_oe", 32'(eth_sd_oe), 32'd0);
        check("rs_locked", 32'(locked), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        req[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack != 2'b00) seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack != 2'b00) seen++;
        end
        check("rs_no_ack", 32'(seen), 32'd0);
        check("rs_idle_after", 32'({busy, locked}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
